mips_mem_slave: RTL and testbench

Word-addressed memory responder for the MIPS core's shared tri-state memory bus. It answers the core's CS/WE/ADDR requests and the single bidirectional 32-bit data bus. It holds program and data RAM, and, when compiled in, a small memory-mapped I/O window (GPIO out, GPIO in, cycle counter, status). It sits at top level opposite the CPU and is the only other driver of Mem_Bus.

---
 rtl/mips_mem_slave_if.sv | 14 +
 rtl/mips_mem_slave.sv | 113 +++++++++++
 tb/tb_mips_mem_slave.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_slave_if.sv
// Shared MIPS memory bus: chip select, write enable, word address and the
// single bidirectional 32-bit data bus.
interface mips_mem_slave_if;
  // Bus protocol: CS=1,WE=0 is a read served combinationally by the slave in
  // the same cycle; CS=1,WE=1 is a write where the master drives Mem_Bus and the
  // slave commits it at the rising edge; CS=0 is idle with Mem_Bus undriven.
  logic        CS;
  logic        WE;
  logic [31:0] ADDR;
  wire  [31:0] Mem_Bus;

  modport master (output CS, output WE, output ADDR, inout Mem_Bus);
  modport slave  (input  CS, input  WE, input  ADDR, inout Mem_Bus);
endinterface

// File: rtl/mips_mem_slave.sv
// Word-addressed RAM responder for the MIPS tri-state memory bus.
// Optional IO window (GPIO out/in, cycle counter, status) enabled by `define MEM_IO_EN.
module mips_mem_slave #(
  parameter int    ADDR_BITS = 7,
  parameter string INIT_FILE = ""
) (
  input  logic                  CLK,
  input  logic                  RST,
  mips_mem_slave_if.slave       bus,
  input  logic [7:0]            gpio_in,
  output logic [7:0]            gpio_out,
  output logic                  bus_err
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [31:0]          mem_q [DEPTH];
  logic [ADDR_BITS-1:0] ram_idx;
  logic                 ram_hit;
  logic                 io_hit;
  logic [3:0]           io_off;
  logic                 access;
  logic                 wr_en;
  logic                 drive_en;
  logic [31:0]          rd_data;
  logic                 bus_err_d, bus_err_q;

  assign ram_idx  = bus.ADDR[ADDR_BITS-1:0];
  assign ram_hit  = (bus.ADDR[31:ADDR_BITS] == '0);
  assign io_off   = bus.ADDR[3:0];
  assign access   = bus.CS & ~RST;
  assign wr_en    = access & bus.WE;
  // Never drive while the core may be driving (WE=1) or while idle/resetting.
  assign drive_en = bus.CS & ~bus.WE & ~RST;

  assign bus.Mem_Bus = drive_en ? rd_data : 'z;

`ifdef MEM_IO_EN
  logic [7:0]  gpio_out_d, gpio_out_q;
  logic [7:0]  sync1_q, sync2_q;
  logic [31:0] cycles_d, cycles_q;
  logic [31:0] io_rd;

  assign io_hit = (bus.ADDR[31:4] == 28'hFFFFFFF);

  always_comb begin
    io_rd = 32'h0;
    case (io_off)
      4'd0:    io_rd = {24'h0, gpio_out_q};
      4'd1:    io_rd = {24'h0, sync2_q};
      4'd2:    io_rd = cycles_q;
      4'd3:    io_rd = {31'h0, bus_err_q};
      default: io_rd = 32'h0;
    endcase
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    cycles_d   = cycles_q + 32'd1;
    if (wr_en && io_hit && io_off == 4'd0) gpio_out_d = bus.Mem_Bus[7:0];
    if (wr_en && io_hit && io_off == 4'd2) cycles_d = 32'h0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      gpio_out_q <= 8'h0;
      sync1_q    <= 8'h0;
      sync2_q    <= 8'h0;
      cycles_q   <= 32'h0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      cycles_q   <= cycles_d;
    end
  end

  assign gpio_out = gpio_out_q;
`else
  logic [31:0] io_rd;
  logic        unused_gpio;

  assign io_hit      = 1'b0;
  assign io_rd       = 32'h0;
  assign unused_gpio = ^gpio_in;
  assign gpio_out    = 8'h0;
`endif

  always_comb begin
    rd_data = 32'h0;
    if (ram_hit)     rd_data = mem_q[ram_idx];
    else if (io_hit) rd_data = io_rd;
  end

  // Set is applied after the W1C so a simultaneous set wins.
  always_comb begin
    bus_err_d = bus_err_q;
    if (wr_en && io_hit && io_off == 4'd3 && bus.Mem_Bus[0]) bus_err_d = 1'b0;
    if (access && !ram_hit && !io_hit) bus_err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) bus_err_q <= 1'b0;
    else     bus_err_q <= bus_err_d;
  end

  always_ff @(posedge CLK) begin
    if (wr_en && ram_hit) mem_q[ram_idx] <= bus.Mem_Bus;
  end

  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mips_mem_slave.sv
// Self-checking bench for mips_mem_slave: vector table plus hand sequences
// for reset, GPIO synchroniser and cycle counter behaviour.
module tb_mips_mem_slave;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  gpio_in = 8'h0;
  logic [7:0]  gpio_out;
  logic        bus_err;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_data = 32'h0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];

  mips_mem_slave_if bus_if ();

  assign bus_if.Mem_Bus = tb_drv ? tb_data : 'z;

  mips_mem_slave #(.ADDR_BITS(7), .INIT_FILE("")) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus_if.slave),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .bus_err  (bus_err)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  typedef struct {
    logic        cs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_bus;
    logic        exp_err;
    logic [7:0]  exp_gpio;
  } vec_t;

  vec_t vecs[32];
  int   n_vec = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic cs, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_bus,
                         input logic exp_err, input logic [7:0] exp_gpio);
    vecs[n_vec].cs       = cs;
    vecs[n_vec].we       = we;
    vecs[n_vec].addr     = addr;
    vecs[n_vec].wdata    = wdata;
    vecs[n_vec].exp_bus  = exp_bus;
    vecs[n_vec].exp_err  = exp_err;
    vecs[n_vec].exp_gpio = exp_gpio;
    n_vec++;
  endtask

  // One bus cycle: inputs at negedge, bus sampled mid-low phase, then the edge.
  // The bench drives the bus whenever the slave must not, so a stray slave drive
  // corrupts the sampled value.
  task automatic do_cycle(input string name, input logic cs, input logic we,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_bus);
    logic [31:0] exp;
    @(negedge CLK);
    bus_if.CS   = cs;
    bus_if.WE   = we;
    bus_if.ADDR = addr;
    tb_drv      = !(cs && !we) || RST;
    tb_data     = data;
    exp_q.push_back(exp_bus);
    #2;
    exp = exp_q.pop_front();
    check(name, bus_if.Mem_Bus, exp);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    bus_if.CS = 1'b0;
    bus_if.WE = 1'b0;
    tb_drv    = 1'b1;
    tb_data   = 32'h0;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) idle_cycle();
    RST = 1'b0;
  endtask

  initial begin
    int k;
    bus_if.CS   = 1'b0;
    bus_if.WE   = 1'b0;
    bus_if.ADDR = 32'h0;

    do_reset(2);
    check("reset_gpio_out", {24'h0, gpio_out}, 32'h0);
    check("reset_bus_err", {31'h0, bus_err}, 32'h0);

    // RAM vectors, identical in both builds
    add_vec(1, 1, 32'h5,   32'hDEADBEEF, 32'hDEADBEEF, 0, 8'h00);
    add_vec(1, 0, 32'h5,   32'h0,        32'hDEADBEEF, 0, 8'h00);
    add_vec(0, 0, 32'h5,   32'h0,        32'h0,        0, 8'h00);
    add_vec(1, 1, 32'h7F,  32'h12345678, 32'h12345678, 0, 8'h00);
    add_vec(1, 0, 32'h7F,  32'h0,        32'h12345678, 0, 8'h00);
    add_vec(1, 0, 32'h5,   32'h0,        32'hDEADBEEF, 0, 8'h00);
    add_vec(1, 1, 32'h0,   32'hCAFEF00D, 32'hCAFEF00D, 0, 8'h00);
    add_vec(1, 0, 32'h0,   32'h0,        32'hCAFEF00D, 0, 8'h00);
    add_vec(1, 1, 32'h80,  32'h55555555, 32'h55555555, 1, 8'h00);
    add_vec(1, 0, 32'h0,   32'h0,        32'hCAFEF00D, 1, 8'h00);
    add_vec(1, 0, 32'h100, 32'h0,        32'h0,        1, 8'h00);
`ifdef MEM_IO_EN
    add_vec(1, 1, 32'hFFFFFFF3, 32'h0,        32'h0,        1, 8'h00);
    add_vec(1, 1, 32'hFFFFFFF3, 32'h1,        32'h1,        0, 8'h00);
    add_vec(1, 0, 32'hFFFFFFF3, 32'h0,        32'h0,        0, 8'h00);
    add_vec(1, 0, 32'h100,      32'h0,        32'h0,        1, 8'h00);
    add_vec(1, 0, 32'hFFFFFFF3, 32'h0,        32'h1,        1, 8'h00);
    add_vec(1, 1, 32'hFFFFFFF3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 8'h00);
    add_vec(1, 1, 32'hFFFFFFF0, 32'h1A5,      32'h1A5,      0, 8'hA5);
    add_vec(1, 0, 32'hFFFFFFF0, 32'h0,        32'hA5,       0, 8'hA5);
    add_vec(1, 1, 32'hFFFFFFF1, 32'hFF,       32'hFF,       0, 8'hA5);
    add_vec(1, 0, 32'hFFFFFFF1, 32'h0,        32'h0,        0, 8'hA5);
    add_vec(1, 0, 32'hFFFFFFF7, 32'h0,        32'h0,        0, 8'hA5);
    add_vec(1, 0, 32'hFFFFFFEF, 32'h0,        32'h0,        1, 8'hA5);
`else
    add_vec(1, 1, 32'hFFFFFFF3, 32'h1,        32'h1,        1, 8'h00);
    add_vec(1, 1, 32'hFFFFFFF0, 32'h1A5,      32'h1A5,      1, 8'h00);
    add_vec(1, 0, 32'hFFFFFFF0, 32'h0,        32'h0,        1, 8'h00);
`endif

    for (int i = 0; i < n_vec; i++) begin
      do_cycle($sformatf("vec%0d_bus", i), vecs[i].cs, vecs[i].we, vecs[i].addr,
               vecs[i].wdata, vecs[i].exp_bus);
      check($sformatf("vec%0d_bus_err", i), {31'h0, bus_err}, {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d_gpio_out", i), {24'h0, gpio_out}, {24'h0, vecs[i].exp_gpio});
    end

    // Reset held during a read: slave must not drive
    RST = 1'b1;
    do_cycle("reset_read_hiz", 1, 0, 32'h5, 32'h0, 32'h0);
    // Reset held during writes: nothing commits
    do_cycle("reset_wr_gpio_bus", 1, 1, 32'hFFFFFFF0, 32'hFF, 32'hFF);
    do_cycle("reset_wr_ram_bus", 1, 1, 32'h5, 32'h11111111, 32'h11111111);
    RST = 1'b0;
    check("reset_wr_gpio_out", {24'h0, gpio_out}, 32'h0);
    check("reset_bus_err_clr", {31'h0, bus_err}, 32'h0);
    do_cycle("reset_wr_ram_kept", 1, 0, 32'h5, 32'h0, 32'hDEADBEEF);

`ifdef MEM_IO_EN
    // GPIO_IN two-flop latency
    do_reset(2);
    @(negedge CLK);
    gpio_in     = 8'h3C;
    bus_if.CS   = 1'b0;
    tb_drv      = 1'b1;
    tb_data     = 32'h0;
    @(posedge CLK);
    #1;
    do_cycle("gpio_in_1edge", 1, 0, 32'hFFFFFFF1, 32'h0, 32'h0);
    do_cycle("gpio_in_2edge", 1, 0, 32'hFFFFFFF1, 32'h0, 32'h3C);

    // Cycle counter from reset, reload, and wrap
    do_reset(2);
    k = $urandom_range(3, 10);
    repeat (k) idle_cycle();
    do_cycle("cycles_after_reset", 1, 0, 32'hFFFFFFF2, 32'h0, k);
    do_cycle("cycles_write_bus", 1, 1, 32'hFFFFFFF2, 32'h1234, 32'h1234);
    do_cycle("cycles_after_write", 1, 0, 32'hFFFFFFF2, 32'h0, 32'h0);
    do_cycle("cycles_resume", 1, 0, 32'hFFFFFFF2, 32'h0, 32'h1);
    @(negedge CLK);
    dut.cycles_q <= 32'hFFFFFFFF;
    bus_if.CS   = 1'b1;
    bus_if.WE   = 1'b0;
    bus_if.ADDR = 32'hFFFFFFF2;
    tb_drv      = 1'b0;
    #2;
    check("cycles_max", bus_if.Mem_Bus, 32'hFFFFFFFF);
    @(posedge CLK);
    #1;
    do_cycle("cycles_wrap", 1, 0, 32'hFFFFFFF2, 32'h0, 32'h0);
    check("cycles_wrap_no_err", {31'h0, bus_err}, 32'h0);
`else
    do_reset(2);
    do_cycle("noio_cycles_read", 1, 0, 32'hFFFFFFF2, 32'h0, 32'h0);
    check("noio_cycles_err", {31'h0, bus_err}, 32'h1);
    check("noio_gpio_out", {24'h0, gpio_out}, 32'h0);
`endif

    idle_cycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
